// File: rtl/audio_preprocessor.sv
// -----------------------------------------------------------------------------
// audio_preprocessor
// Selectable 4-tap FIR pre-filter for a signed PCM stream, one sample per clock.
// The four-sample tap history is shared by every mode, so changing the mode
// never flushes it; the new mode simply applies to the next computed output.
//
// Ports
//   i_clk         system clock, all state updates on the rising edge
//   i_rst         synchronous active-low reset (0 = clear taps and output)
//   i_filter_sel  0 = low-pass (4-tap average), 1 = high-pass (x0-x1)/2,
//                 2 = band-pass (x0-x2)/2, 3 = bypass (x0)
//   i_audio_in    signed input sample, a new one every clock
//   o_audio_out   signed filtered sample, registered
// -----------------------------------------------------------------------------
module audio_preprocessor #(
  parameter int DATA_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [1:0]               i_filter_sel,
  input  logic signed [DATA_W-1:0] i_audio_in,
  output logic signed [DATA_W-1:0] o_audio_out
);

  // Two guard bits: a four-term sum of DATA_W-bit values fits exactly.
  localparam int ACC_W = DATA_W + 2;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {3'b000, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {3'b111, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0] r_x0, r_x1, r_x2, r_x3;

  logic signed [ACC_W-1:0]  w_e0, w_e1, w_e2, w_e3;
  logic signed [ACC_W-1:0]  w_y;
  logic signed [DATA_W-1:0] w_sat;

  always_comb begin
    w_e0 = {{2{r_x0[DATA_W-1]}}, r_x0};
    w_e1 = {{2{r_x1[DATA_W-1]}}, r_x1};
    w_e2 = {{2{r_x2[DATA_W-1]}}, r_x2};
    w_e3 = {{2{r_x3[DATA_W-1]}}, r_x3};

    // All operands are signed, so >>> floors toward -inf with no rounding.
    unique case (i_filter_sel)
      2'd0:    w_y = (w_e0 + w_e1 + w_e2 + w_e3) >>> 2;
      2'd1:    w_y = (w_e0 - w_e1) >>> 1;
      2'd2:    w_y = (w_e0 - w_e2) >>> 1;
      default: w_y = w_e0;
    endcase

    // The formulas cannot leave the DATA_W range today, but the clamp keeps
    // any future coefficient change from wrapping around and flipping sign.
    if (w_y > SAT_MAX) begin
      w_sat = SAT_MAX[DATA_W-1:0];
    end else if (w_y < SAT_MIN) begin
      w_sat = SAT_MIN[DATA_W-1:0];
    end else begin
      w_sat = w_y[DATA_W-1:0];
    end
  end

  // Taps shift and the output is computed from the pre-edge taps on the same
  // edge, giving two edges from sample capture to its first effect on output.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_x0        <= '0;
      r_x1        <= '0;
      r_x2        <= '0;
      r_x3        <= '0;
      o_audio_out <= '0;
    end else begin
      r_x3        <= r_x2;
      r_x2        <= r_x1;
      r_x1        <= r_x0;
      r_x0        <= i_audio_in;
      o_audio_out <= w_sat;
    end
  end

endmodule

// File: tb/tb_audio_preprocessor.sv
module tb_audio_preprocessor;

  logic               clk;
  logic               rst;
  logic [1:0]         sel;
  logic signed [15:0] din;
  logic signed [15:0] dout;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit                 rst;
    logic [1:0]         sel;
    logic signed [15:0] din;
    logic signed [15:0] exp;
    string              tag;
  } vec_t;

  vec_t tbl[$];

  audio_preprocessor #(.DATA_W(16)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_filter_sel (sel),
    .i_audio_in   (din),
    .o_audio_out  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive away from the rising edge, sample 1 time unit after it.
  task automatic apply(input bit r, input logic [1:0] s, input logic signed [15:0] d,
                       input logic signed [15:0] e, input string tag);
    @(negedge clk);
    rst = r;
    sel = s;
    din = d;
    @(posedge clk);
    #1;
    n_vec++;
    if (dout !== e) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (rst=%0b sel=%0d in=%0d)",
               tag, dout, e, r, s, d);
    end
  endtask

  function automatic void add(input bit r, input int s, input int d, input int e,
                              input string tag);
    vec_t v;
    v.rst = r;
    v.sel = 2'(s);
    v.din = 16'(d);
    v.exp = 16'(e);
    v.tag = tag;
    tbl.push_back(v);
  endfunction

  // Reference: the filter definitions computed on plain integers.
  function automatic int ref_filter(input int s, input int a0, input int a1,
                                    input int a2, input int a3);
    int y;
    case (s)
      0:       y = (a0 + a1 + a2 + a3) >>> 2;
      1:       y = (a0 - a1) >>> 1;
      2:       y = (a0 - a2) >>> 1;
      default: y = a0;
    endcase
    if (y > 32767)  y = 32767;
    if (y < -32768) y = -32768;
    return y;
  endfunction

  initial begin
    int hist[4];
    rst = 1'b0;
    sel = 2'd0;
    din = '0;

    // reset held with input present
    add(0, 0, 1000, 0, "reset_hold0");
    add(0, 0, 1000, 0, "reset_hold1");
    add(0, 0, 1000, 0, "reset_hold2");
    add(1, 3, 1000, 0, "reset_release");
    // bypass, two-edge delay
    add(1, 3, 5,      1000,   "bypass0");
    add(1, 3, -7,     5,      "bypass1");
    add(1, 3, 32767,  -7,     "bypass2");
    add(1, 3, -32768, 32767,  "bypass3");
    add(1, 3, 0,      -32768, "bypass4");
    // LPF step
    add(0, 0, 0,   0,   "lpf_rst");
    add(1, 0, 400, 0,   "lpf_step0");
    add(1, 0, 400, 100, "lpf_step1");
    add(1, 0, 400, 200, "lpf_step2");
    add(1, 0, 400, 300, "lpf_step3");
    add(1, 0, 400, 400, "lpf_step4");
    add(1, 0, 400, 400, "lpf_step5");
    // LPF impulse
    add(0, 0, 0,   0,   "imp_rst");
    add(1, 0, 400, 0,   "imp0");
    add(1, 0, 0,   100, "imp1");
    add(1, 0, 0,   100, "imp2");
    add(1, 0, 0,   100, "imp3");
    add(1, 0, 0,   100, "imp4");
    add(1, 0, 0,   0,   "imp5");
    // HPF step (taps are all zero here)
    add(1, 1, 400, 0,   "hpf_step0");
    add(1, 1, 400, 200, "hpf_step1");
    add(1, 1, 400, 0,   "hpf_step2");
    // BPF step
    add(0, 2, 0,   0,   "bpf_rst");
    add(1, 2, 400, 0,   "bpf_step0");
    add(1, 2, 400, 200, "bpf_step1");
    add(1, 2, 400, 200, "bpf_step2");
    add(1, 2, 400, 0,   "bpf_step3");
    // HPF floor on negative odd difference
    add(0, 1, 0,  0,  "floor_rst");
    add(1, 1, -1, 0,  "floor0");
    add(1, 1, 0,  -1, "floor1");
    add(1, 1, 0,  0,  "floor2");
    // HPF at the extremes, no wrap
    add(0, 1, 0,      0,      "ext_rst");
    add(1, 1, 32767,  0,      "ext0");
    add(1, 1, -32768, 16383,  "ext1");
    add(1, 1, 32767,  -32768, "ext2");
    add(1, 1, -32768, 32767,  "ext3");
    add(1, 1, 32767,  -32768, "ext4");
    // mid-stream mode switch and reset pulse
    add(0, 0, 0,   0,   "mid_rst");
    add(1, 0, 100, 0,   "mid0");
    add(1, 0, 100, 25,  "mid1");
    add(1, 0, 100, 50,  "mid2");
    add(1, 0, 100, 75,  "mid3");
    add(1, 0, 100, 100, "mid4");
    add(1, 1, 100, 0,   "mid_switch");
    add(0, 0, 100, 0,   "mid_pulse");
    add(1, 0, 100, 0,   "mid_restart0");
    add(1, 0, 100, 25,  "mid_restart1");

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].sel, tbl[i].din, tbl[i].exp, tbl[i].tag);
    end

    // Randomized run against the reference; begins with a forced reset so the
    // model history and the DUT agree.
    for (int k = 0; k < 4; k++) hist[k] = 0;
    for (int i = 0; i < 3000; i++) begin
      bit                 r;
      int                 s;
      int                 d;
      int                 e;
      logic signed [15:0] dv;
      r = (i == 0) ? 1'b0 : ($urandom_range(0, 31) != 0);
      s = int'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0:       dv = 16'sh7FFF;
        1:       dv = 16'sh8000;
        2:       dv = 16'($urandom_range(0, 7)) - 16'sd4;
        default: dv = 16'($urandom);
      endcase
      d = int'(dv);
      if (!r) begin
        e = 0;
        for (int k = 0; k < 4; k++) hist[k] = 0;
      end else begin
        e = ref_filter(s, hist[0], hist[1], hist[2], hist[3]);
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = d;
      end
      apply(r, 2'(s), dv, 16'(e), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
